// File: rtl/reg_file_pkg.sv
// Shared widths, register types and the zero constant for the multi-port register file.
package reg_file_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_data_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of read, write, reserve and scoreboard signals between decode/writeback and the register file.
interface reg_file_mp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [(2**ADDR_W)-1:0]   busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins on a same-cycle clash.
module reg_file_scoreboard #(
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [(2**ADDR_W)-1:0]   busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  always_comb begin
    busy_next = busy_reg;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        busy_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    // Applied after the clears so a new producer supersedes the retiring one.
    if (rsv_en) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with r0 hardwired to zero, registered reads and a busy scoreboard.
// Build option: REG_FILE_MP_BYPASS_EN forwards same-cycle write data to reads of the same address.
module reg_file_mp #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input logic         clk,
  input logic         reset,
  reg_file_mp_if.slave bus
);
  import reg_file_pkg::*;

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Ascending port order: the last assignment, from the highest-index port, wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] != '0)) begin
          mem_reg[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_read_port
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rd_data_next;
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;

      assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_data_next = mem_reg[addr];
`ifdef REG_FILE_MP_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
            rd_data_next = bus.wr_data[w*DATA_W +: DATA_W];
          end
        end
`endif
        if (addr == '0) begin
          rd_data_next = DATA_W'(REG_ZERO);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= bus.rd_en[gi];
          if (bus.rd_en[gi]) begin
            rd_data_reg <= rd_data_next;
          end
        end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = rd_data_reg;
      assign bus.rd_valid[gi]                 = rd_valid_reg;
    end
  endgenerate

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .busy     (bus.busy)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed vector table plus randomized run against an array-based reference model of reg_file_mp.
module tb_reg_file_mp;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 2;
  localparam int NW = 2;
`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] rd_en;
    logic [2:0] ra0, ra1;
    logic [1:0] wr_en;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       rsv;
    logic [2:0] rsa;
    logic [1:0] ev;
    logic [7:0] ed0, ed1;
    logic [7:0] eb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(string name, logic rst, logic [1:0] rd_en, logic [2:0] ra0, logic [2:0] ra1,
                              logic [1:0] wr_en, logic [2:0] wa0, logic [2:0] wa1, logic [7:0] wd0,
                              logic [7:0] wd1, logic rsv, logic [2:0] rsa, logic [1:0] ev,
                              logic [7:0] ed0, logic [7:0] ed1, logic [7:0] eb);
    vec_t v;
    v.name = name; v.rst = rst; v.rd_en = rd_en; v.ra0 = ra0; v.ra1 = ra1;
    v.wr_en = wr_en; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.rsv = rsv; v.rsa = rsa; v.ev = ev; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    reset        = v.rst;
    bus.rd_en    = v.rd_en;
    bus.rd_addr  = {v.ra1, v.ra0};
    bus.wr_en    = v.wr_en;
    bus.wr_addr  = {v.wa1, v.wa0};
    bus.wr_data  = {v.wd1, v.wd0};
    bus.rsv_en   = v.rsv;
    bus.rsv_addr = v.rsa;
    @(posedge clk);
    #1;
    $display("txn %-12s rst=%0b rd_en=%b ra=%0d/%0d wr_en=%b wa=%0d/%0d wd=%02h/%02h rsv=%0b@%0d -> valid=%b data=%02h/%02h busy=%02h",
             v.name, v.rst, v.rd_en, v.ra0, v.ra1, v.wr_en, v.wa0, v.wa1, v.wd0, v.wd1, v.rsv, v.rsa,
             bus.rd_valid, bus.rd_data[7:0], bus.rd_data[15:8], bus.busy);
    check({v.name, ".valid"}, {6'd0, bus.rd_valid}, {6'd0, v.ev});
    check({v.name, ".data0"}, bus.rd_data[7:0], v.ed0);
    check({v.name, ".data1"}, bus.rd_data[15:8], v.ed1);
    check({v.name, ".busy"}, bus.busy, v.eb);
  endtask

  // Reference model state
  logic [7:0] m_mem [8];
  logic [7:0] m_busy;
  logic [7:0] m_d [2];
  logic [1:0] m_v;

  initial begin
    logic [7:0] col;
    reset = 1'b1;
    bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.rsv_en = 1'b0; bus.rsv_addr = '0;

    col = BYPASS ? 8'h33 : 8'h10;
    vecs.push_back(mk("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk("rst_read", 0, 2'b11, 3'(i), 3'(i), 0, 0, 0, 0, 0, 0, 0, 2'b11, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("wr_r3", 0, 0, 0, 0, 2'b01, 3, 0, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("rd_r3", 0, 2'b10, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2'b10, 8'h00, 8'hA5, 8'h00));
    vecs.push_back(mk("rd_r3_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'h00));
    vecs.push_back(mk("wr_r0", 0, 0, 0, 0, 2'b11, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 8'hA5, 8'h00));
    vecs.push_back(mk("rd_r0", 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("wr_conflict", 0, 0, 0, 0, 2'b11, 5, 5, 8'h11, 8'h22, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("rd_r5", 0, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 8'h22, 8'h00, 8'h00));
    vecs.push_back(mk("wr_r2", 0, 0, 0, 0, 2'b10, 0, 2, 0, 8'h10, 0, 0, 0, 8'h22, 8'h00, 8'h00));
    vecs.push_back(mk("collide_r2", 0, 2'b01, 2, 0, 2'b01, 2, 0, 8'h33, 0, 0, 0, 2'b01, col, 8'h00, 8'h00));
    vecs.push_back(mk("rd_r2_after", 0, 2'b10, 0, 2, 0, 0, 0, 0, 0, 0, 0, 2'b10, col, 8'h33, 8'h00));
    vecs.push_back(mk("rsv_r4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, col, 8'h33, 8'h10));
    vecs.push_back(mk("rsv_wr_r4", 0, 0, 0, 0, 2'b01, 4, 0, 8'h44, 0, 1, 4, 0, col, 8'h33, 8'h10));
    vecs.push_back(mk("wr_r4", 0, 0, 0, 0, 2'b10, 0, 4, 0, 8'h55, 0, 0, 0, col, 8'h33, 8'h00));
    vecs.push_back(mk("rsv_r4_again", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, col, 8'h33, 8'h10));
    vecs.push_back(mk("rsv_r0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, col, 8'h33, 8'h10));
    vecs.push_back(mk("mid_reset", 1, 2'b11, 4, 4, 2'b01, 6, 0, 8'h77, 0, 1, 4, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("rd_after_rst", 0, 2'b11, 6, 4, 0, 0, 0, 0, 0, 0, 0, 2'b11, 8'h00, 8'h00, 8'h00));
    foreach (vecs[i]) apply(vecs[i]);

    // Multi-cycle: reserve coinciding with two writers, then a lone writeback retires it.
    apply(mk("seq_rsv_2wr", 0, 0, 0, 0, 2'b11, 7, 7, 8'h66, 8'h77, 1, 7, 0, 8'h00, 8'h00, 8'h80));
    apply(mk("seq_wb_r7", 0, 0, 0, 0, 2'b01, 7, 0, 8'h88, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    apply(mk("seq_rd_r7", 0, 2'b11, 7, 7, 0, 0, 0, 0, 0, 0, 0, 2'b11, 8'h88, 8'h88, 8'h00));
    apply(mk("seq_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h88, 8'h88, 8'h00));

    // Randomized phase; the first cycle is a reset so the model starts clean.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic [2:0] ra [2];
      logic [2:0] wa [2];
      logic [7:0] wd [2];
      v = mk("rand", (n == 0) || ($urandom_range(0, 49) == 0), 2'($urandom), 3'($urandom), 3'($urandom),
             2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 3'($urandom), 0, 0, 0, 0);
      ra[0] = v.ra0; ra[1] = v.ra1; wa[0] = v.wa0; wa[1] = v.wa1; wd[0] = v.wd0; wd[1] = v.wd1;
      if (v.rst) begin
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_busy = 8'h00; m_d[0] = 8'h00; m_d[1] = 8'h00; m_v = 2'b00;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (v.rd_en[p]) begin
            logic [7:0] val;
            val = (ra[p] == 0) ? 8'h00 : m_mem[ra[p]];
            if (BYPASS && ra[p] != 0)
              for (int w = 0; w < 2; w++)
                if (v.wr_en[w] && wa[w] == ra[p]) val = wd[w];
            m_d[p] = val;
          end
        end
        m_v = v.rd_en;
        for (int w = 0; w < 2; w++) begin
          if (v.wr_en[w] && wa[w] != 0) begin
            m_mem[wa[w]] = wd[w];
            m_busy[wa[w]] = 1'b0;
          end
        end
        if (v.rsv && v.rsa != 0) m_busy[v.rsa] = 1'b1;
      end
      v.ev = m_v; v.ed0 = m_d[0]; v.ed1 = m_d[1]; v.eb = m_busy;
      apply(v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the 8-bit datapath CPU: NUM_RD read ports, NUM_WR write ports, and a per-register busy scoreboard.
- Reads and writes proceed in the same cycle, with no read blocking during a write.
- Register 0 is hardwired to zero.
- Sits between decode (read/reserve) and writeback (write/clear busy).

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W, including hardwired r0
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports; higher index has priority

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_valid  out  NUM_RD  high for the cycle after the matching rd_en
- wr_en  in  NUM_WR  per-port write strobe
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses
- wr_data  in  NUM_WR*DATA_W  packed write data
- rsv_en  in  1  reserve strobe: mark destination busy
- rsv_addr  in  ADDR_W  register to reserve
- busy  out  2**ADDR_W  scoreboard vector; bit i means register i is awaiting writeback; bit 0 is always 0

Behaviour:
- Reset (reset high at posedge):
  - All registers go to 0; rd_data goes to 0; rd_valid goes to 0; busy goes to 0.
  - Reset dominates every other input in that cycle.
  - Asserting reset mid-sequence discards pending reservations and any same-cycle writes.
- Read:
  - Latency is 1 cycle.
  - If rd_en[p] is high at edge N, rd_data[p] holds file[rd_addr[p]] at edge N+1 and rd_valid[p] is high for exactly that cycle.
  - If rd_en[p] is low, rd_data[p] holds its previous value and rd_valid[p] is 0.
  - Reading address 0 returns 0.
- Write:
  - If wr_en[w] is high and wr_addr[w] != 0, file[wr_addr[w]] is updated to wr_data[w] at the edge.
  - Writes to address 0 are ignored.
  - If two or more ports write the same address in the same cycle, the highest-index port wins.
- Read/write collision, same address in the same cycle: the result depends on BYPASS_EN (see Optional Feature).
- Scoreboard:
  - rsv_en with rsv_addr != 0 sets busy[rsv_addr] at the edge.
  - Any enabled write to address a != 0 clears busy[a].
  - If a set and a clear hit the same register in the same cycle, set wins (a new producer supersedes the old one).
  - Reserving an already-busy register keeps it busy.
  - Reserving r0 is ignored.
  - busy is a direct register output with no combinational path from the inputs.
- Arithmetic: none; data passes through unchanged. Addresses are always in range by construction (2**ADDR_W entries).

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: a read of address a in the same cycle as an enabled write to a returns the new write data, using the same highest-index-write-port-wins rule. A read of r0 still returns 0.
- Undefined: such a read returns the old stored value, and the new value is visible from the next read onward.
- Scoreboard behaviour is identical in both builds.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W and ADDR_W localparams
  - typedef reg_addr_t (logic [ADDR_W-1:0])
  - typedef reg_data_t (logic [DATA_W-1:0])
  - constant REG_ZERO = '0
- Sub-module reg_file_scoreboard (clk, reset, rsv_en, rsv_addr, wr_en, wr_addr, busy) holds the busy vector and its set-wins rule.
- The storage array and read ports stay in reg_file_mp.

Test Plan:
- Reset check: hold reset for 2 cycles, then read r1..r7 on both ports -> rd_data = 0 and busy = 0 on every read.
- Simple write/read: write port 0 sends r3 = 0xA5; next cycle read r3 on port 1 -> rd_data[1] = 0xA5 one cycle later, rd_valid[1] = 1 for one cycle only.
- Write to r0: write 0xFF to r0 via both ports, then read r0 -> 0x00.
- Same-address write conflict: port 0 writes r5 = 0x11 and port 1 writes r5 = 0x22 in the same cycle; then read r5 -> 0x22.
- Read/write collision: read r2 (holding 0x10) while writing r2 = 0x33 in the same cycle -> rd_data = 0x10 without REG_FILE_MP_BYPASS_EN, 0x33 with it.
- Scoreboard:
  - rsv r4 -> busy[4] = 1.
  - rsv r4 and write r4 in the same cycle -> busy[4] stays 1.
  - Write r4 alone -> busy[4] = 0.
  - rsv r4, then reset the next cycle -> busy = 0.
